// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Imported by fetch_ctrl and fetch_slot.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_slot.sv
// One-entry IF/ID output register.
// Flush beats load, and load beats consume.
module fetch_slot
    import fetch_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              take,
    input  logic              flush,
    input  logic [INST_W-1:0] load_inst,
    input  logic [AW-1:0]     load_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [AW-1:0]     pc,
    output logic [AW-1:0]     pc4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
            pc4   <= load_pc + AW'(PC_STEP);
        end else if (take && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request
// at a time and kills responses made stale by a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          AW       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [AW-1:0]     redirect_pc,
    input  logic              id_ready,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [AW-1:0]     if_pc,
    output logic [AW-1:0]     if_pc4
);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_n;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_addr_n;
    logic          kill;
    logic          kill_n;
    logic          load;
    logic [AW-1:0] tgt;

    assign tgt = redirect_pc & ~AW'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= AW'(RESET_PC);
            req_addr <= '0;
            kill     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            kill     <= kill_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        kill_n     = kill;
        load       = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = '0;
        unique case (state)
            IDLE: begin
                if (!if_valid || id_ready) begin
                    state_n    = REQ;
                    req_addr_n = redirect_valid ? tgt : pc;
                end
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (imem_gnt) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_n = IDLE;
                    kill_n  = 1'b0;
                    if (!kill && !redirect_valid) begin
                        load = 1'b1;
                        pc_n = req_addr + AW'(PC_STEP);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // A response still owed by memory must be dropped on arrival.
        if (redirect_valid) begin
            pc_n = tgt;
            if (state == REQ || (state == WAIT && !imem_rvalid)) begin
                kill_n = 1'b1;
            end
        end
    end

    fetch_slot #(
        .AW(AW)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .take     (id_ready),
        .flush    (redirect_valid),
        .load_inst(imem_rdata),
        .load_pc  (req_addr),
        .valid    (if_valid),
        .inst     (if_inst),
        .pc       (if_pc),
        .pc4      (if_pc4)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(negedge clk);
    endtask

    // Expects to be entered in REQ for address a; leaves the bench in IDLE
    // with the slot just loaded.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a) begin
            errors++;
            $display("FAIL fetch_req got req=%b addr=%h exp req=1 addr=%h",
                     imem_req, imem_addr, a);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_slot_busy got %b exp 0", if_valid);
        end
        imem_gnt = 1'b1;
        step;
        imem_gnt = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait got req=%b valid=%b exp 0 0",
                     imem_req, if_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        step;
        imem_rvalid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== d || if_pc !== a ||
            if_pc4 !== a + 32'd4) begin
            errors++;
            $display("FAIL fetch_slot got v=%b i=%h pc=%h pc4=%h exp 1 %h %h %h",
                     if_valid, if_inst, if_pc, if_pc4, d, a, a + 32'd4);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        checks++;
        if ({if_valid, if_inst, if_pc, if_pc4, imem_req, imem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b i=%h pc=%h pc4=%h req=%b a=%h exp 0",
                     if_valid, if_inst, if_pc, if_pc4, imem_req, imem_addr);
        end
        rst = 1'b0;
        step;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req got req=%b a=%h exp 1 0",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait;
        do_fetch(32'h0, 32'hA000_0000);
        step;
        do_fetch(32'h4, 32'hA000_0004);
    endtask

    task automatic test_stall;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 ||
                if_inst !== 32'hA000_0004 || if_pc !== 32'h4) begin
                errors++;
                $display("FAIL stall_hold c%0d got req=%b v=%b i=%h pc=%h exp 0 1 a0000004 4",
                         i, imem_req, if_valid, if_inst, if_pc);
            end
        end
        id_ready = 1'b1;
        step;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_resume got req=%b a=%h exp 1 8", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait;
        imem_gnt = 1'b1;
        step;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait got req=%b v=%b exp 0 0", imem_req, if_valid);
        end
        step;
        step;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step;
        imem_rvalid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || if_inst === 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL redir_kill got v=%b i=%h exp v=0 and not deadbeef",
                     if_valid, if_inst);
        end
        step;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_target got req=%b a=%h exp 1 100", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        do_fetch(32'h100, 32'hB000_0100);
        step;
        imem_gnt = 1'b1;
        step;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hBAD0_0104;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop got v=%b exp 0", if_valid);
        end
        step;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL b2b_req200 got req=%b a=%h exp 1 200", imem_req, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        for (int i = 0; i < 2; i++) begin
            step;
            redirect_valid = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                errors++;
                $display("FAIL b2b_hold c%0d got req=%b a=%h exp 1 200",
                         i, imem_req, imem_addr);
            end
        end
        imem_gnt = 1'b1;
        step;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0200;
        step;
        imem_rvalid = 1'b0;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_discard got v=%b i=%h exp 0", if_valid, if_inst);
        end
        step;
        do_fetch(32'h300, 32'hC000_0300);
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step;
        redirect_valid = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'hE000_FFFC);
        step;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next got req=%b a=%h exp 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid;
        do_fetch(32'h0, 32'hF000_0000);
        step;
        imem_gnt = 1'b1;
        step;
        imem_gnt = 1'b0;
        rst      = 1'b1;
        step;
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h57A1_E000;
        checks++;
        if ({if_valid, if_inst, if_pc, if_pc4, imem_req, imem_addr} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b i=%h pc=%h pc4=%h req=%b a=%h exp 0",
                     if_valid, if_inst, if_pc, if_pc4, imem_req, imem_addr);
        end
        step;
        imem_rvalid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || if_inst !== 32'h0) begin
            errors++;
            $display("FAIL midreset_stale got v=%b i=%h exp 0 0", if_valid, if_inst);
        end
        do_fetch(32'h0, 32'h1234_5678);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        test_reset;
        test_zero_wait;
        test_stall;
        test_redirect_wait;
        test_back_to_back;
        test_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
